divider: RTL and testbench

//  Iterative 32-bit restoring divider for the MIPS multiply/divide unit. It is the

---
 rtl/mips_mdu_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/divider.sv | 106 ++++++++++
 tb/tb_divider.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_mdu_pkg.sv
// rtl/mips_mdu_pkg.sv - shared constants and FSM state type for the multiply/divide unit
package mips_mdu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step on the packed {rem,quo} register
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem_quo,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rem_quo_next
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;
  logic           ge;

  // The shifted remainder is WIDTH+1 bits; since rem < divisor before the shift,
  // bit WIDTH of the difference is exactly the borrow.
  always_comb begin
    partial      = rem_quo[2*WIDTH-1:WIDTH-1];
    diff         = partial - {1'b0, divisor};
    ge           = ~diff[WIDTH];
    rem_quo_next = {(ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0]), rem_quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative restoring divider for DIV/DIVU (quotient to LO, remainder to HI)
module divider
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sign,
  input  logic             enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divready,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t         state, next_state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] rem_quo, rem_quo_next;
  logic [WIDTH-1:0]   dvsr, dvd_raw;
  logic               neg_quo, neg_rem, zero_dvsr;
  logic [WIDTH-1:0]   abs_dvd, abs_dvs;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_quo      (rem_quo),
    .divisor      (dvsr),
    .rem_quo_next (rem_quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = enable ? LOAD : IDLE;
      LOAD:    next_state = enable ? ITER : IDLE;
      ITER:    next_state = !enable ? IDLE : ((count == '0) ? FIX : ITER);
      FIX:     next_state = enable ? DONE : IDLE;
      DONE:    next_state = enable ? DONE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Magnitudes are plain WIDTH-bit negations, so the most negative value maps to itself.
  always_comb begin
    divready = (state == DONE);
    abs_dvd  = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    abs_dvs  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    fix_quo  = neg_quo ? -rem_quo[WIDTH-1:0]       : rem_quo[WIDTH-1:0];
    fix_rem  = neg_rem ? -rem_quo[2*WIDTH-1:WIDTH] : rem_quo[2*WIDTH-1:WIDTH];
    if (zero_dvsr) begin
      fix_quo = '1;
      fix_rem = dvd_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_quo     <= '0;
      dvsr        <= '0;
      dvd_raw     <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      zero_dvsr   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          rem_quo   <= {{WIDTH{1'b0}}, abs_dvd};
          dvsr      <= abs_dvs;
          dvd_raw   <= dividend;
          neg_quo   <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem   <= sign & dividend[WIDTH-1];
          zero_dvsr <= (divisor == '0);
          count     <= CW'(WIDTH - 1);
        end
        ITER: begin
          if (enable) begin
            rem_quo <= rem_quo_next;
            count   <= count - CW'(1);
          end
        end
        FIX: begin
          if (enable) begin
            quotient    <= fix_quo;
            remainder   <= fix_rem;
            div_by_zero <= zero_dvsr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider against an arithmetic reference
module tb_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sign = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        divready, div_by_zero;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sign        (sign),
    .enable      (enable),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .divready    (divready),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS DIV/DIVU semantics: truncation toward zero, remainder follows the dividend.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc;
    ref_div(s, a, b, eq, er, ez);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    sign = s; dividend = a; divisor = b; enable = 1'b1;
    cyc = 0;
    while (!divready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s.latency", tag), 32'(cyc - 1), 32'd34);
    check($sformatf("%s.quotient", tag), quotient, eq);
    check($sformatf("%s.remainder", tag), remainder, er);
    check($sformatf("%s.div_by_zero", tag), {31'd0, div_by_zero}, {31'd0, ez});
    dividend = ~a; divisor = b + 32'd3; sign = ~s;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s.hold_ready", tag), {31'd0, divready}, 32'd1);
    check($sformatf("%s.hold_quotient", tag), quotient, eq);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s.ready_fall", tag), {31'd0, divready}, 32'd0);
    check($sformatf("%s.keep_remainder", tag), remainder, er);
  endtask

  initial begin
    logic [31:0] prev_q, prev_r;
    logic [31:0] rb;
    logic        seen;

    #1;
    check("reset.quotient", quotient, 32'd0);
    check("reset.remainder", remainder, 32'd0);
    check("reset.divready", {31'd0, divready}, 32'd0);
    check("reset.div_by_zero", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_div("divu_7_2", 1'b0, 32'd7, 32'd2);
    run_div("div_m8_2", 1'b1, 32'hFFFF_FFF8, 32'd2);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    run_div("div_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    prev_q = quotient;
    prev_r = remainder;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    sign = 1'b0; dividend = 32'd100; divisor = 32'd7; enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (divready) seen = 1'b1;
    end
    check("abort.no_ready", {31'd0, seen}, 32'd0);
    check("abort.quotient", quotient, prev_q);
    check("abort.remainder", remainder, prev_r);
    run_div("abort_restart", 1'b0, 32'd100, 32'd7);

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    sign = 1'b0; dividend = 32'h0000_FFFF; divisor = 32'h10; enable = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.quotient", quotient, 32'd0);
    check("midreset.remainder", remainder, 32'd0);
    check("midreset.divready", {31'd0, divready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    run_div("after_reset", 1'b0, 32'h0000_FFFF, 32'h10);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 300);
        3:       rb = -$urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
